can_tx_framer: RTL

CAN transmit framer feeding the serial CRC-15 stage (`can_crc`). It latches one frame's fields in parallel and shifts the frame out MSB-first, one bit per `bit_tick`. It drives the CRC stage's enable and data inputs for the covered bits, then appends the CRC returned by that stage, followed by the fixed recessive trailer. Bit stuffing is not done here; a downstream stuffer consumes `tx_bit`.

---
 rtl/can_pkg.sv | 52 +++++
 rtl/can_tx_framer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/can_pkg.sv
// Frame geometry, field widths and FSM encoding shared by the CAN transmit path.
// The frame is 90 bits: 65 CRC-covered bits, a 15-bit CRC field, then a recessive trailer.
package can_pkg;

    localparam int ID_W   = 11;
    localparam int CTRL_W = 7;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int PAD_W  = 14;
    localparam int CRC_W  = 15;

    // First transmitted index of each frame field.
    localparam int SOF_IDX       = 0;
    localparam int ID_IDX        = 1;
    localparam int CTRL_IDX      = 12;
    localparam int RW_IDX        = 19;
    localparam int ADDR_IDX      = 20;
    localparam int DATA_IDX      = 35;
    localparam int PAD_IDX       = 51;
    localparam int CRC_IDX       = 65;
    localparam int CRC_DELIM_IDX = 80;
    localparam int ACK_IDX       = 81;
    localparam int ACK_DELIM_IDX = 82;
    localparam int EOF_IDX       = 83;

    localparam int   FRAME_BITS     = 90;
    localparam int   CRC_COVER_BITS = 65;
    localparam int   CNT_W          = 7;
    localparam logic RECESSIVE      = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        PAYLOAD,
        CRC,
        TRAILER
    } tx_state_t;

    typedef logic [CRC_COVER_BITS-1:0] payload_t;

    // CRC-covered part of the frame, SOF in the MSB so it shifts out first.
    function automatic payload_t pack_payload(
        input logic [ID_W-1:0]   id,
        input logic [CTRL_W-1:0] ctrl,
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {1'b0, id, ctrl, rw, addr, wdata, {PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/can_tx_framer.sv
// Serialises one CAN frame per tx_start, feeding the external CRC-15 stage for the
// covered bits and appending the CRC it returns, then the recessive trailer.
module can_tx_framer
    import can_pkg::*;
#(
    parameter int TICK_MIN = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              bit_tick,
    input  logic              tx_start,
    input  logic [ID_W-1:0]   tx_id,
    input  logic [CTRL_W-1:0] tx_ctrl,
    input  logic              tx_rw,
    input  logic [ADDR_W-1:0] tx_addr,
    input  logic [DATA_W-1:0] tx_wdata,
    input  logic [CRC_W-1:0]  crc_in,
    output logic              tx_bit,
    output logic              crc_en,
    output logic              crc_data,
    output logic              crc_clr,
    output logic              tx_busy,
    output logic              tx_done
);

    if (TICK_MIN < 2 ||
        ID_IDX != SOF_IDX + 1 || CTRL_IDX != ID_IDX + ID_W ||
        RW_IDX != CTRL_IDX + CTRL_W || ADDR_IDX != RW_IDX + 1 ||
        DATA_IDX != ADDR_IDX + ADDR_W || PAD_IDX != DATA_IDX + DATA_W ||
        CRC_IDX != PAD_IDX + PAD_W || CRC_COVER_BITS != CRC_IDX ||
        CRC_DELIM_IDX != CRC_IDX + CRC_W || ACK_IDX != CRC_DELIM_IDX + 1 ||
        ACK_DELIM_IDX != ACK_IDX + 1 || EOF_IDX != ACK_DELIM_IDX + 1 ||
        FRAME_BITS != EOF_IDX + 7) begin : g_bad_config
        $error("can_tx_framer: TICK_MIN below 2 or inconsistent frame geometry");
    end

    localparam logic [CNT_W-1:0] LAST_COVER_CNT = CNT_W'(CRC_COVER_BITS - 1);
    localparam logic [CNT_W-1:0] FIRST_CRC_CNT  = CNT_W'(CRC_IDX);
    localparam logic [CNT_W-1:0] LAST_CRC_CNT   = CNT_W'(CRC_DELIM_IDX - 1);
    localparam logic [CNT_W-1:0] END_CNT        = CNT_W'(FRAME_BITS);

    tx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    payload_t         payload_q;
    logic [CRC_W-1:0] crc_sr_q;
    logic             tx_bit_q;
    logic             crc_en_q;
    logic             crc_data_q;
    logic             crc_clr_q;
    logic             tx_busy_q;
    logic             tx_done_q;

    logic             start_accept;
    logic [CRC_W-1:0] crc_src;
    logic             crc_bit_d;
    logic [CRC_W-1:0] crc_sr_d;

    assign start_accept = (state_q == IDLE) && tx_start;

    // The first CRC bit comes straight from crc_in; later ones from the captured copy.
    assign crc_src   = (cnt_q == FIRST_CRC_CNT) ? crc_in : crc_sr_q;
    assign crc_bit_d = crc_src[CRC_W-1];
    assign crc_sr_d  = crc_src << 1;

    // NOTE: sequential state uses <= so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_bit_q   <= RECESSIVE;
            crc_en_q   <= 1'b0;
            crc_data_q <= 1'b0;
            crc_clr_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            crc_en_q  <= 1'b0;
            crc_clr_q <= 1'b0;
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_bit_q <= RECESSIVE;
                    if (tx_start) begin
                        state_q   <= START;
                        crc_clr_q <= 1'b1;
                        tx_busy_q <= 1'b1;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= PAYLOAD;
                end
                PAYLOAD: if (bit_tick) begin
                    tx_bit_q   <= payload_q[CRC_COVER_BITS-1];
                    crc_data_q <= payload_q[CRC_COVER_BITS-1];
                    crc_en_q   <= 1'b1;
                    cnt_q      <= cnt_q + 1'b1;
                    if (cnt_q == LAST_COVER_CNT) state_q <= CRC;
                end
                CRC: if (bit_tick) begin
                    tx_bit_q <= crc_bit_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CRC_CNT) state_q <= TRAILER;
                end
                TRAILER: if (bit_tick) begin
                    // The counter parks one past the last index until the closing tick.
                    if (cnt_q == END_CNT) begin
                        state_q   <= IDLE;
                        tx_busy_q <= 1'b0;
                        tx_done_q <= 1'b1;
                    end else begin
                        tx_bit_q <= RECESSIVE;
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the field and CRC shift registers carry no reset; each is loaded before it is shifted out.
    always_ff @(posedge clk) begin
        if (start_accept) begin
            payload_q <= pack_payload(tx_id, tx_ctrl, tx_rw, tx_addr, tx_wdata);
        end else if (state_q == PAYLOAD && bit_tick) begin
            payload_q <= payload_q << 1;
        end
        if (state_q == CRC && bit_tick) begin
            crc_sr_q <= crc_sr_d;
        end
    end

    assign tx_bit   = tx_bit_q;
    assign crc_en   = crc_en_q;
    assign crc_data = crc_data_q;
    assign crc_clr  = crc_clr_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule
